// File: rtl/host_rd_engine.sv
// -----------------------------------------------------------------------------
// host_rd_engine
//
// Walks a 2-D memory region (line_count lines of line_bytes each, line starts
// spaced by line_stride word addresses) and issues one-beat burst reads to the
// memory arbiter. Returned beats are forwarded to an external host-side FIFO.
// New requests are gated by credits so that every beat in flight already has
// a free FIFO slot reserved.
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; region registers latched on start
//   S_REQ   | issuing read requests, throttled by credit and outstanding cap
//   S_DRAIN | no new requests; waiting for all in-flight beats to return
//   S_DONE  | one-cycle completion pulse, aborted flag valid
//
// Ports
//   clk, reset_clk                 memory clock, synchronous active-high reset
//   start, abort                   single-cycle control pulses
//   base_addr, line_bytes,
//   line_count, line_stride        region description, sampled on start
//   busy, done, aborted            status
//   err_underrun                   sticky: beat returned with nothing in flight
//   mem_rd_req/addr/ack            read request handshake
//   mem_rd_data/data_valid         read return
//   out_free                       free entries in the host FIFO
//   out_wr_en, out_din             host FIFO write (one cycle after return)
//   outstanding                    requests acknowledged but not yet returned
// -----------------------------------------------------------------------------
module host_rd_engine #(
    parameter int DATA_W          = 128,
    parameter int ADDR_W          = 29,
    parameter int ADDR_INC        = 8,
    parameter int LEN_W           = 24,
    parameter int MAX_OUTSTANDING = 32,
    parameter int FREE_W          = 10
) (
    input  logic              clk,
    input  logic              reset_clk,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  line_bytes,
    input  logic [LEN_W-1:0]  line_count,
    input  logic [ADDR_W-1:0] line_stride,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err_underrun,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_data_valid,
    input  logic [FREE_W-1:0] out_free,
    output logic              out_wr_en,
    output logic [DATA_W-1:0] out_din,
    output logic [7:0]        outstanding
);

    localparam int BEAT_SHIFT = $clog2(DATA_W / 8);
    localparam int SUM_W      = ((FREE_W > 8) ? FREE_W : 8) + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   line_base_q, line_base_d;
    logic [LEN_W-1:0]    beats_left_q, beats_left_d;
    logic [LEN_W-1:0]    lines_left_q, lines_left_d;
    logic [LEN_W-1:0]    beats_per_line_q, beats_per_line_d;
    logic                abort_q, abort_d;
    logic [7:0]          outst_q, outst_d;
    logic                err_q, err_d;
    logic                wr_en_q;
    logic [DATA_W-1:0]   din_q;

    logic                hs;
    logic [LEN_W-1:0]    start_beats;
    logic                last_beat;
    logic                last_line;
    logic                run_finished;
    logic                credit_ok;
    logic                cap_ok;
    logic                permit;

    assign hs           = req_q & mem_rd_ack;
    assign start_beats  = line_bytes >> BEAT_SHIFT;
    assign last_beat    = (beats_left_q == LEN_W'(1));
    assign last_line    = (lines_left_q == LEN_W'(1));
    assign run_finished = hs & last_beat & last_line;

    // The handshake completing this cycle already occupies a FIFO slot and an
    // outstanding slot, so it is counted before deciding on the next request.
    assign credit_ok = (SUM_W'(outst_q) + SUM_W'(hs) + SUM_W'(1)) <= SUM_W'(out_free);
    assign cap_ok    = (SUM_W'(outst_q) + SUM_W'(hs)) < SUM_W'(MAX_OUTSTANDING);
    assign permit    = credit_ok & cap_ok;

    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        addr_d           = addr_q;
        line_base_d      = line_base_q;
        beats_left_d     = beats_left_q;
        lines_left_d     = lines_left_q;
        beats_per_line_d = beats_per_line_q;
        abort_d          = abort_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    line_base_d      = base_addr;
                    addr_d           = base_addr;
                    beats_left_d     = start_beats;
                    beats_per_line_d = start_beats;
                    lines_left_d     = line_count;
                    abort_d          = 1'b0;
                    if ((start_beats == '0) || (line_count == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                        req_d   = permit;
                    end
                end
            end

            S_REQ: begin
                if (hs) begin
                    if (last_beat) begin
                        lines_left_d = lines_left_q - LEN_W'(1);
                        line_base_d  = line_base_q + line_stride;
                        addr_d       = line_base_q + line_stride;
                        beats_left_d = beats_per_line_q;
                    end else begin
                        beats_left_d = beats_left_q - LEN_W'(1);
                        addr_d       = addr_q + ADDR_W'(ADDR_INC);
                    end
                end

                if (req_q && !mem_rd_ack) begin
                    // A raised request is never withdrawn; an abort seen now
                    // takes effect once this request is accepted.
                    req_d   = 1'b1;
                    abort_d = abort_q | abort;
                end else if (run_finished) begin
                    // The whole region went out this cycle; an abort arriving
                    // together with the final acceptance has nothing to stop.
                    req_d   = 1'b0;
                    state_d = S_DRAIN;
                end else if (abort_q || abort) begin
                    req_d   = 1'b0;
                    abort_d = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    req_d = permit;
                end
            end

            S_DRAIN: begin
                if (outst_q == 8'd0) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (hs && !mem_rd_data_valid) begin
            outst_d = outst_q + 8'd1;
        end else if (!hs && mem_rd_data_valid) begin
            if (outst_q == 8'd0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state_q          <= S_IDLE;
            req_q            <= 1'b0;
            addr_q           <= '0;
            line_base_q      <= '0;
            beats_left_q     <= '0;
            lines_left_q     <= '0;
            beats_per_line_q <= '0;
            abort_q          <= 1'b0;
            outst_q          <= 8'd0;
            err_q            <= 1'b0;
            wr_en_q          <= 1'b0;
            din_q            <= '0;
        end else begin
            state_q          <= state_d;
            req_q            <= req_d;
            addr_q           <= addr_d;
            line_base_q      <= line_base_d;
            beats_left_q     <= beats_left_d;
            lines_left_q     <= lines_left_d;
            beats_per_line_q <= beats_per_line_d;
            abort_q          <= abort_d;
            outst_q          <= outst_d;
            err_q            <= err_d;
            wr_en_q          <= mem_rd_data_valid;
            din_q            <= mem_rd_data;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign aborted      = (state_q == S_DONE) & abort_q;
    assign err_underrun = err_q;
    assign mem_rd_req   = req_q;
    assign mem_rd_addr  = addr_q;
    assign out_wr_en    = wr_en_q;
    assign out_din      = din_q;
    assign outstanding  = outst_q;

endmodule

// File: tb/tb_host_rd_engine.sv
// -----------------------------------------------------------------------------
// tb_host_rd_engine
//
// Stimulus process drives the region, control pulses and a memory responder
// (ack delay, return latency, random data). Expected request addresses come
// from a nested-loop region model; expected host writes are queued when a beat
// is returned. A negedge monitor pops and compares both queues and tracks the
// in-flight count from the observed handshakes and returns.
// -----------------------------------------------------------------------------
module tb_host_rd_engine;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 29;
    localparam int LEN_W  = 24;
    localparam int FREE_W = 10;
    localparam int MAXO   = 32;

    logic              clk = 1'b0;
    logic              reset_clk;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  line_bytes;
    logic [LEN_W-1:0]  line_count;
    logic [ADDR_W-1:0] line_stride;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              err_underrun;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_data_valid;
    logic [FREE_W-1:0] out_free;
    logic              out_wr_en;
    logic [DATA_W-1:0] out_din;
    logic [7:0]        outstanding;

    host_rd_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_INC(8), .LEN_W(LEN_W),
        .MAX_OUTSTANDING(MAXO), .FREE_W(FREE_W)
    ) dut (
        .clk(clk), .reset_clk(reset_clk), .start(start), .abort(abort),
        .base_addr(base_addr), .line_bytes(line_bytes), .line_count(line_count),
        .line_stride(line_stride), .busy(busy), .done(done), .aborted(aborted),
        .err_underrun(err_underrun), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
        .mem_rd_data_valid(mem_rd_data_valid), .out_free(out_free),
        .out_wr_en(out_wr_en), .out_din(out_din), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                due;
    } out_t;

    out_t              exp_out[$];
    logic [ADDR_W-1:0] exp_addr[$];
    int                ret_q[$];

    int total = 0;
    int bad   = 0;
    int tick_idx = 0;
    int ne_idx   = 0;
    int hs_count, first_hs, last_hs, wr_cnt, done_cnt;
    int ack_lo, ack_hi, cur_ack, wait_cnt, lat_lo, lat_hi;
    bit ret_en, stray, exp_aborted;
    int mon_out;
    logic prev_req, prev_ack, prev_rst;
    logic [ADDR_W-1:0] prev_addr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: wait for the edge, then act as the memory for the next edge.
    task automatic tick();
        logic [DATA_W-1:0] d;
        @(posedge clk);
        #1;
        tick_idx++;
        mem_rd_ack        = 1'b0;
        mem_rd_data_valid = 1'b0;
        if (!reset_clk) begin
            if (stray || (ret_en && ret_q.size() > 0 && ret_q[0] <= tick_idx)) begin
                if (!stray) void'(ret_q.pop_front());
                stray = 1'b0;
                d = rand_beat();
                mem_rd_data       = d;
                mem_rd_data_valid = 1'b1;
                exp_out.push_back('{d: d, due: ne_idx + 2});
            end
            if (mem_rd_req) begin
                if (wait_cnt >= cur_ack) begin
                    mem_rd_ack = 1'b1;
                    wait_cnt   = 0;
                    cur_ack    = $urandom_range(ack_hi, ack_lo);
                    if (hs_count == 0) first_hs = tick_idx;
                    last_hs = tick_idx;
                    hs_count++;
                    ret_q.push_back(tick_idx + $urandom_range(lat_hi, lat_lo));
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        out_t o;
        logic [ADDR_W-1:0] a;
        ne_idx++;
        if (reset_clk) begin
            mon_out = 0;
        end else begin
            chk("outstanding", 128'(outstanding), 128'(mon_out));
            if (prev_req && !prev_ack && !prev_rst) begin
                chk("req_held", 128'(mem_rd_req), 128'(1));
                chk("addr_stable", 128'(mem_rd_addr), 128'(prev_addr));
            end
            if (out_wr_en) begin
                wr_cnt++;
                if (exp_out.size() == 0) begin
                    total++; bad++;
                    $display("FAIL out_write: got unexpected write 0x%0h expected none", out_din);
                end else begin
                    o = exp_out.pop_front();
                    chk("out_din", out_din, o.d);
                    chk("out_latency", 128'(ne_idx), 128'(o.due));
                end
            end
            if (mem_rd_req && mem_rd_ack) begin
                if (exp_addr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_addr: got extra request 0x%0h expected none", mem_rd_addr);
                end else begin
                    a = exp_addr.pop_front();
                    chk("req_addr", 128'(mem_rd_addr), 128'(a));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_aborted", 128'(aborted), 128'(exp_aborted));
                chk("done_busy", 128'(busy), 128'(1));
                chk("done_outstanding", 128'(outstanding), 128'(0));
                if (exp_aborted) exp_addr.delete();
                else chk("done_addr_left", 128'(exp_addr.size()), 128'(0));
            end
            if (mem_rd_req && mem_rd_ack && !mem_rd_data_valid) mon_out++;
            else if (!(mem_rd_req && mem_rd_ack) && mem_rd_data_valid && mon_out > 0) mon_out--;
        end
        prev_req  = mem_rd_req;
        prev_ack  = mem_rd_ack;
        prev_addr = mem_rd_addr;
        prev_rst  = reset_clk;
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   128'(mem_rd_req), 128'(0));
        chk({tag, "_addr"},  128'(mem_rd_addr), 128'(0));
        chk({tag, "_busy"},  128'(busy), 128'(0));
        chk({tag, "_done"},  128'(done), 128'(0));
        chk({tag, "_abrt"},  128'(aborted), 128'(0));
        chk({tag, "_err"},   128'(err_underrun), 128'(0));
        chk({tag, "_wren"},  128'(out_wr_en), 128'(0));
        chk({tag, "_din"},   out_din, 128'(0));
        chk({tag, "_outst"}, 128'(outstanding), 128'(0));
    endtask

    task automatic set_mem(input int alo, input int ahi, input int llo, input int lhi);
        ack_lo = alo; ack_hi = ahi; lat_lo = llo; lat_hi = lhi;
        cur_ack = $urandom_range(ahi, alo);
        wait_cnt = 0;
    endtask

    // Region model: every line start is base + l*stride, beats step by 8.
    task automatic launch(input logic [ADDR_W-1:0] b, input int lb, input int lc,
                          input logic [ADDR_W-1:0] s);
        logic [63:0] a;
        for (int l = 0; l < lc; l++) begin
            for (int k = 0; k < lb / 16; k++) begin
                a = 64'(b) + 64'(l) * 64'(s) + 64'(k) * 64'd8;
                exp_addr.push_back(a[ADDR_W-1:0]);
            end
        end
        hs_count = 0; wr_cnt = 0; exp_aborted = 1'b0;
        base_addr = b; line_bytes = LEN_W'(lb); line_count = LEN_W'(lc); line_stride = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        total++;
        if (done_cnt == d0) begin
            bad++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
        tick();
        chk({name, "_out_left"}, 128'(exp_out.size()), 128'(0));
    endtask

    initial begin
        int lb, lc, total_beats, abort_at;
        bit do_abort;
        int d0;

        reset_clk = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; line_bytes = '0; line_count = '0; line_stride = '0;
        mem_rd_ack = 1'b0; mem_rd_data = '0; mem_rd_data_valid = 1'b0;
        out_free = 10'd500; ret_en = 1'b1; stray = 1'b0;
        hs_count = 0; wr_cnt = 0; done_cnt = 0; mon_out = 0; exp_aborted = 1'b0;
        first_hs = 0; last_hs = 0;
        set_mem(0, 0, 3, 3);
        repeat (3) tick();
        chk_reset_vals("rst");
        reset_clk = 1'b0;
        tick();

        // Basic run
        launch(29'h100, 64, 1, 29'h0);
        chk("basic_req_rise", 128'(mem_rd_req), 128'(1));
        chk("basic_busy", 128'(busy), 128'(1));
        wait_done("basic", 200);
        chk("basic_nreq", 128'(hs_count), 128'(4));
        chk("basic_b2b", 128'(last_hs - first_hs), 128'(3));
        chk("basic_nwr", 128'(wr_cnt), 128'(4));
        chk("basic_busy_end", 128'(busy), 128'(0));

        // 2-D stride
        launch(29'h1000, 32, 3, 29'h400);
        wait_done("stride", 300);
        chk("stride_nreq", 128'(hs_count), 128'(6));

        // Address wrap
        launch(29'h1FFF_FFF8, 64, 1, 29'h0);
        wait_done("wrap", 200);
        chk("wrap_nreq", 128'(hs_count), 128'(4));

        // Empty region
        launch(29'h40, 64, 0, 29'h0);
        chk("empty_done", 128'(done), 128'(1));
        chk("empty_busy", 128'(busy), 128'(1));
        tick();
        chk("empty_done_fall", 128'(done), 128'(0));
        chk("empty_busy_fall", 128'(busy), 128'(0));
        chk("empty_nreq", 128'(hs_count), 128'(0));

        // Credit throttle
        ret_en = 1'b0; out_free = 10'd2;
        launch(29'h2000, 256, 1, 29'h0);
        repeat (20) tick();
        chk("credit2_nreq", 128'(hs_count), 128'(2));
        chk("credit2_req_low", 128'(mem_rd_req), 128'(0));
        out_free = 10'd10;
        repeat (20) tick();
        chk("credit10_nreq", 128'(hs_count), 128'(10));
        chk("credit10_req_low", 128'(mem_rd_req), 128'(0));
        chk("credit10_outst", 128'(outstanding), 128'(10));
        ret_en = 1'b1; out_free = 10'd500;
        wait_done("credit", 300);
        chk("credit_nwr", 128'(wr_cnt), 128'(16));

        // Abort while a request waits for its ack
        set_mem(5, 5, 3, 3);
        launch(29'h3000, 256, 1, 29'h0);
        tick(); tick();
        chk("abort_req_pending", 128'(mem_rd_req), 128'(1));
        abort = 1'b1;
        exp_aborted = (hs_count < 16);
        tick();
        abort = 1'b0;
        chk("abort_req_still", 128'(mem_rd_req), 128'(1));
        wait_done("abort", 300);
        chk("abort_nreq", 128'(hs_count), 128'(1));
        chk("abort_nwr", 128'(wr_cnt), 128'(1));

        // Randomized regions, memory timing, credits and aborts
        for (int r = 0; r < 25; r++) begin
            set_mem(0, $urandom_range(2, 0), 1, $urandom_range(6, 1));
            out_free = FREE_W'($urandom_range(40, 1));
            lb = 16 * $urandom_range(6, 1);
            lc = $urandom_range(4, 1);
            total_beats = (lb / 16) * lc;
            do_abort = ($urandom_range(9, 0) < 3);
            abort_at = $urandom_range(30, 0);
            launch(ADDR_W'($urandom()), lb, lc, ADDR_W'($urandom()));
            d0 = done_cnt;
            for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
                if (do_abort && i == abort_at) begin
                    abort = 1'b1;
                    exp_aborted = (hs_count < total_beats);
                end
                tick();
                abort = 1'b0;
            end
            total++;
            if (done_cnt == d0) begin
                bad++;
                $display("FAIL rand%0d_timeout: got no done expected done", r);
            end
            tick();
            chk("rand_out_left", 128'(exp_out.size()), 128'(0));
            if (!do_abort) chk("rand_nreq", 128'(hs_count), 128'(total_beats));
        end
        chk("rand_err_clear", 128'(err_underrun), 128'(0));

        // Stray return with nothing in flight
        out_free = 10'd500;
        set_mem(0, 0, 3, 3);
        stray = 1'b1;
        tick();
        tick();
        chk("stray_err", 128'(err_underrun), 128'(1));
        chk("stray_outst", 128'(outstanding), 128'(0));
        tick();
        chk("stray_err_sticky", 128'(err_underrun), 128'(1));

        // Reset with five requests in flight
        ret_en = 1'b0;
        launch(29'h5000, 256, 2, 29'h800);
        for (int i = 0; i < 50 && outstanding != 8'd5; i++) tick();
        chk("midrst_outst", 128'(outstanding), 128'(5));
        reset_clk = 1'b1;
        mem_rd_ack = 1'b0;
        tick();
        chk_reset_vals("midrst");
        reset_clk = 1'b0;
        ret_q.delete(); exp_addr.delete(); exp_out.delete();
        ret_en = 1'b1;
        tick();

        // Clean run after reset
        launch(29'h100, 64, 1, 29'h0);
        wait_done("post_rst", 200);
        chk("post_rst_nreq", 128'(hs_count), 128'(4));
        chk("post_rst_err", 128'(err_underrun), 128'(0));
        chk("post_rst_aborted_seen", 128'(exp_aborted), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
